// File: rtl/jzjpcc_mmio_controller.sv
// Memory-mapped I/O block: NUM_PORTS output registers, synchronized inputs with
// sticky rising-edge capture, per-port interrupt mask and a registered irq.
module jzjpcc_mmio_controller #(
  parameter int NUM_PORTS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [31:2]               busAddr,
  input  logic [31:0]               busWriteData,
  input  logic                      busWriteEnable,
  input  logic                      busReadEnable,
  output logic                      busHit,
  output logic [31:0]               busReadData,
  input  logic [NUM_PORTS-1:0][31:0] mmioInputs,
  output logic [NUM_PORTS-1:0][31:0] mmioOutputs,
  output logic                      irq
);

  // Word layout of the window, from its lowest word upward:
  // mask, edge[0..N-1], data[0..N-1]; the data block ends at the top of memory.
  localparam logic [29:0] MASK_WORD = 30'((64'd1 << 30) - 64'(2 * NUM_PORTS) - 64'd1);

  typedef logic [NUM_PORTS-1:0][31:0] port_vec_t;

  port_vec_t            sync_q [SYNC_STAGES];
  port_vec_t            sync_last;
  port_vec_t            prev_q;
  port_vec_t            edge_q;
  port_vec_t            edge_next;
  logic [NUM_PORTS-1:0] mask_q;
  logic [NUM_PORTS-1:0] edge_sel;
  logic [NUM_PORTS-1:0] data_sel;
  logic [NUM_PORTS-1:0] edge_any;
  logic                 mask_sel;
  logic                 wr;
  logic                 rd;
  logic [29:0]          offset;
  logic [31:0]          read_mux;

  // Bus strobes are single-cycle qualifiers with no back-pressure: a read or
  // write takes place on any rising edge where its enable and busHit are both 1.
  assign busHit    = (busAddr >= MASK_WORD);
  assign offset    = busAddr - MASK_WORD;
  assign wr        = busWriteEnable && busHit;
  assign rd        = busReadEnable && busHit;
  assign sync_last = sync_q[SYNC_STAGES-1];

  always_comb begin
    edge_sel  = '0;
    data_sel  = '0;
    edge_any  = '0;
    edge_next = '0;
    read_mux  = '0;
    mask_sel  = busHit && (offset == 30'd0);
    if (mask_sel) read_mux = 32'(mask_q);
    for (int i = 0; i < NUM_PORTS; i++) begin
      edge_sel[i] = busHit && (offset == 30'(i + 1));
      data_sel[i] = busHit && (offset == 30'(i + 1 + NUM_PORTS));
      edge_any[i] = |edge_q[i];
      if (edge_sel[i]) read_mux = edge_q[i];
      if (data_sel[i]) read_mux = sync_last[i];
      // Clear is applied before set so a simultaneous new edge survives.
      edge_next[i] = (edge_q[i] & ~((wr && edge_sel[i]) ? busWriteData : 32'd0))
                   | (sync_last[i] & ~prev_q[i]);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev_q      <= '0;
      edge_q      <= '0;
      mask_q      <= '0;
      mmioOutputs <= '0;
      busReadData <= '0;
      irq         <= 1'b0;
    end else begin
      sync_q[0] <= mmioInputs;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q      <= sync_last;
      edge_q      <= edge_next;
      irq         <= |(mask_q & edge_any);
      busReadData <= rd ? read_mux : 32'd0;
      if (wr && mask_sel) mask_q <= busWriteData[NUM_PORTS-1:0];
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (wr && data_sel[i]) mmioOutputs[i] <= busWriteData;
      end
    end
  end

endmodule

// File: tb/tb_jzjpcc_mmio_controller.sv
// Randomized and directed bench for jzjpcc_mmio_controller, checked against a
// byte-address, snapshot-history reference model.
module tb_jzjpcc_mmio_controller;

  localparam int N = 8;
  localparam int S = 2;
  localparam logic [31:0] DATA_BA = 32'(64'h1_0000_0000 - 64'(4 * N));
  localparam logic [31:0] EDGE_BA = DATA_BA - 32'(4 * N);
  localparam logic [31:0] MASK_BA = EDGE_BA - 32'd4;

  typedef logic [N-1:0][31:0] vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:2] busAddr = '0;
  logic [31:0] busWriteData = '0;
  logic        busWriteEnable = 1'b0;
  logic        busReadEnable = 1'b0;
  logic        busHit;
  logic [31:0] busReadData;
  vec_t        mmioInputs = '0;
  vec_t        mmioOutputs;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  vec_t        in_vec = '0;
  vec_t        hist[$];
  logic [31:0] m_out  [N];
  logic [31:0] m_edge [N];
  logic [N-1:0] m_mask;
  logic [31:0] m_rd;
  logic        m_irq;

  jzjpcc_mmio_controller #(.NUM_PORTS(N), .SYNC_STAGES(S)) dut (
    .clock          (clock),
    .reset          (reset),
    .busAddr        (busAddr),
    .busWriteData   (busWriteData),
    .busWriteEnable (busWriteEnable),
    .busReadEnable  (busReadEnable),
    .busHit         (busHit),
    .busReadData    (busReadData),
    .mmioInputs     (mmioInputs),
    .mmioOutputs    (mmioOutputs),
    .irq            (irq)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    hist = {};
    for (int k = 0; k <= S; k++) hist.push_front('0);
    for (int i = 0; i < N; i++) begin
      m_out[i]  = '0;
      m_edge[i] = '0;
    end
    m_mask = '0;
    m_rd   = '0;
    m_irq  = 1'b0;
  endfunction

  function automatic logic model_hit(input logic [31:0] ba);
    return ba >= MASK_BA;
  endfunction

  // Advance the model by one rising edge using the values driven before it.
  function automatic void model_step(input logic [31:0] ba, input logic [31:0] wd,
                                     input logic we, input logic re);
    vec_t s = hist[S-1];
    vec_t p = hist[S];
    logic hit = model_hit(ba);
    logic irq_n = 1'b0;
    logic [31:0] rd_n = '0;
    int idx;
    if (re && hit) begin
      if (ba == MASK_BA) rd_n = 32'(m_mask);
      else if (ba >= DATA_BA) begin
        idx = int'((ba - DATA_BA) >> 2);
        rd_n = s[idx];
      end else begin
        idx = int'((ba - EDGE_BA) >> 2);
        rd_n = m_edge[idx];
      end
    end
    for (int i = 0; i < N; i++) if (m_mask[i] && (m_edge[i] != 0)) irq_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (we && hit && ba == EDGE_BA + 32'(4 * i)) m_edge[i] = m_edge[i] & ~wd;
      m_edge[i] = m_edge[i] | (s[i] & ~p[i]);
      if (we && hit && ba == DATA_BA + 32'(4 * i)) m_out[i] = wd;
    end
    if (we && hit && ba == MASK_BA) m_mask = wd[N-1:0];
    m_rd  = rd_n;
    m_irq = irq_n;
    hist.push_front(in_vec);
    void'(hist.pop_back());
  endfunction

  task automatic compare_all();
    for (int i = 0; i < N; i++) check($sformatf("out%0d", i), mmioOutputs[i], m_out[i]);
    check("rdata", busReadData, m_rd);
    check("irq", {31'd0, irq}, {31'd0, m_irq});
  endtask

  // One bus cycle: drive, check the combinational hit, clock, check state.
  task automatic cycle(input logic [31:0] ba, input logic [31:0] wd,
                       input logic we, input logic re);
    busAddr        = ba[31:2];
    busWriteData   = wd;
    busWriteEnable = we;
    busReadEnable  = re;
    mmioInputs     = in_vec;
    #2;
    check("hit", {31'd0, busHit}, {31'd0, model_hit(ba)});
    @(posedge clock);
    model_step(ba, wd, we, re);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(32'h0000_1000, 32'd0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] ba, wd;
    logic we, re;
    int r;

    model_reset();
    repeat (2) @(posedge clock);
    #1;
    compare_all();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Output register write and readback of the data port
    cycle(32'hFFFF_FFE4, 32'hDEAD_BEEF, 1'b1, 1'b0);
    check("req029_out1", mmioOutputs[1], 32'hDEAD_BEEF);
    check("req029_out0", mmioOutputs[0], 32'd0);
    cycle(32'hFFFF_FFE4, 32'd0, 1'b0, 1'b1);

    // Synchronizer latency as seen through a data-port read
    in_vec[3] = 32'h5;
    cycle(32'hFFFF_FFEC, 32'd0, 1'b0, 1'b1);
    check("req030_e1", busReadData, 32'd0);
    cycle(32'hFFFF_FFEC, 32'd0, 1'b0, 1'b1);
    check("req030_e2", busReadData, 32'd0);
    cycle(32'hFFFF_FFEC, 32'd0, 1'b0, 1'b1);
    check("req030_e3", busReadData, 32'h5);

    // Masked edge capture, irq timing and write-1-to-clear
    in_vec[3] = 32'd0;
    idle(3);
    cycle(32'hFFFF_FFCC, 32'hFFFF_FFFF, 1'b1, 1'b0);
    cycle(32'hFFFF_FFBC, 32'h0000_0008, 1'b1, 1'b0);
    idle(2);
    in_vec[3] = 32'h1;
    idle(3);
    check("req031_irq_e3", {31'd0, irq}, 32'd0);
    cycle(32'hFFFF_FFCC, 32'd0, 1'b0, 1'b1);
    check("req031_edge", busReadData, 32'h1);
    check("req031_irq_e4", {31'd0, irq}, 32'd1);
    cycle(32'hFFFF_FFCC, 32'h1, 1'b1, 1'b0);
    idle(1);
    check("req031_irq_clr", {31'd0, irq}, 32'd0);

    // Clear collides with a fresh rising edge: set wins
    in_vec[3] = 32'd0;
    idle(3);
    in_vec[3] = 32'h1;
    idle(2);
    cycle(32'hFFFF_FFCC, 32'h1, 1'b1, 1'b0);
    cycle(32'hFFFF_FFCC, 32'd0, 1'b0, 1'b1);
    check("req032_keep", busReadData, 32'h1);

    // Read while clearing returns the pre-clear value
    cycle(32'hFFFF_FFCC, 32'h1, 1'b1, 1'b1);
    check("req033_old", busReadData, 32'h1);
    cycle(32'hFFFF_FFCC, 32'd0, 1'b0, 1'b1);
    check("req033_new", busReadData, 32'd0);

    // Asynchronous reset in the middle of a read, input held high through it
    cycle(32'hFFFF_FFE0, 32'h1234_5678, 1'b1, 1'b0);
    in_vec[0] = 32'h1;
    busAddr = 30'h3FFF_FFF8;
    busReadEnable = 1'b1;
    busWriteEnable = 1'b0;
    mmioInputs = in_vec;
    #1;
    reset = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    // the edge after the one above was the first post-release sample
    model_step(32'h0000_1000, 32'd0, 1'b0, 1'b0);
    compare_all();
    idle(2);
    cycle(32'hFFFF_FFC0, 32'd0, 1'b0, 1'b1);
    check("req034_edge0", busReadData, 32'h1);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      r = $urandom_range(0, 9);
      if (r == 0) ba = $urandom() & 32'hFFFF_FFFC;
      else if (r == 1) ba = MASK_BA - 32'(4 * $urandom_range(1, 4));
      else ba = MASK_BA + 32'(4 * $urandom_range(0, 2 * N));
      wd = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom();
      we = ($urandom_range(0, 2) == 0);
      re = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 2) == 0) begin
        r = $urandom_range(0, N - 1);
        in_vec[r][$urandom_range(0, 31)] ^= 1'b1;
      end
      cycle(ba, wd, we, re);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/jzjpcc_mmio_controller.md
JZJPCC_MMIO_CONTROLLER -- requirements
Module: jzjpcc_mmio_controller

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 8, number of 32-bit MMIO ports (legal 1..16).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, input synchronizer depth (legal 2..3).
REQ-003 SHALL have port clock, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-low reset (0 = in reset).
REQ-005 SHALL have port busAddr, input, [31:2], word address from memory stage.
REQ-006 SHALL have port busWriteData, input, 32, word write data.
REQ-007 SHALL have port busWriteEnable, input, 1, whole-word write strobe.
REQ-008 SHALL have port busReadEnable, input, 1, whole-word read strobe.
REQ-009 SHALL have port busHit, output, 1, combinational; 1 when busAddr is inside the window.
REQ-010 SHALL have port busReadData, output, 32, registered read data.
REQ-011 SHALL have port mmioInputs, input, 32 x NUM_PORTS, asynchronous external inputs.
REQ-012 SHALL have port mmioOutputs, output, 32 x NUM_PORTS, output registers.
REQ-013 SHALL have port irq, output, 1, registered edge-capture interrupt.

Function
REQ-014 Address map: DATA_BASE = 2^32 - 4*NUM_PORTS; EDGE_BASE = DATA_BASE - 4*NUM_PORTS; MASK_ADDR = EDGE_BASE - 4; window = [MASK_ADDR, 0xFFFFFFFC]; NUM_PORTS=8 gives data 0xFFFFFFE0..FC, edge 0xFFFFFFC0..DC, mask 0xFFFFFFBC.
REQ-015 busHit SHALL be 1 iff busAddr*4 lies in the window; strobes with busHit=0 SHALL be ignored.
REQ-016 Each mmioInputs bit SHALL pass through a SYNC_STAGES flop chain; sync[i] denotes the last stage.
REQ-017 Write to DATA_BASE+4i SHALL load mmioOutputs[i] at that edge; read SHALL return sync[i].
REQ-018 prev[i] SHALL register sync[i] each cycle; bit b of edge[i] SHALL set when sync[i][b]=1 and prev[i][b]=0 (sticky).
REQ-019 Write to EDGE_BASE+4i SHALL clear edge[i] bits where busWriteData=1 (write-1-to-clear); read returns edge[i].
REQ-020 Same-cycle set and clear on one edge bit: set SHALL win.
REQ-021 Mask register mask[NUM_PORTS-1:0] at MASK_ADDR; write loads busWriteData[NUM_PORTS-1:0]; read returns mask zero-extended.
REQ-022 irq SHALL register OR over i of (mask[i] AND |edge[i]), one cycle after edge/mask state.
REQ-023 Read latency SHALL be 1: busReadData updates at the edge where busReadEnable=1 and busHit=1, with the value before any same-cycle write to that address; otherwise busReadData SHALL be 0 after that edge.
REQ-024 Simultaneous read and write to same address: read returns old value, write takes effect.
REQ-025 Input change to sync[i] latency SHALL be exactly SYNC_STAGES edges; to edge bit +1; to irq +2.

Reset
REQ-026 While reset=0: mmioOutputs, sync chains, prev, edge, mask, busReadData, irq SHALL all be 0, asynchronously.
REQ-027 An input bit already 1 at reset release SHALL be captured as a rising edge SYNC_STAGES+1 edges later.
REQ-028 Reset asserted mid-operation SHALL discard pending reads; busReadData 0 on first post-reset cycle.

Verification
REQ-029 Write 0xDEADBEEF to 0xFFFFFFE4, then read -> mmioOutputs[1]=0xDEADBEEF next edge; other outputs 0.
REQ-030 mmioInputs[3]=0x00000005 -> read 0xFFFFFFEC returns 0 before SYNC_STAGES edges, 0x5 after.
REQ-031 mask=0x08, mmioInputs[3] bit0 0->1 -> edge[3]=0x1 at +3 edges (SYNC_STAGES=2), irq=1 at +4; write 0x1 to 0xFFFFFFCC -> irq=0 one edge after clear.
REQ-032 Clear edge[3] bit0 in same cycle as new rising edge on bit0 -> bit remains 1.
REQ-033 Read 0xFFFFFFCC while writing 0x1 there -> busReadData = pre-clear value; subsequent read 0.
REQ-034 Assert reset mid-read with outputs loaded -> all outputs, irq, busReadData 0 immediately; input held 1 through release -> edge bit set at SYNC_STAGES+1.
